keypad_scan_sequencer: RTL
==========================

KEYPAD_SCAN_SEQUENCER -- requirements
Module: keypad_scan_sequencer

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clk cycles per row dwell (one "tick"); legal range >= 4.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 16: consecutive matching ticks needed to accept a press or a release; legal range 1..255.
REQ-003 SHALL have parameter REPEAT_DLY, default 500: ticks from key accept to first auto-repeat (used only with KEYPAD_REPEAT_EN).
REQ-004 SHALL have parameter REPEAT_RATE, default 100: ticks between auto-repeats (used only with KEYPAD_REPEAT_EN).
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port column  input  4  keypad columns, active-low, asynchronous to clk.
REQ-008 SHALL have port row  output  4  row drive, active-low, exactly one bit low.
REQ-009 SHALL have port key_valid  output  1  a key code is pending.
REQ-010 SHALL have port key_code  output  4  pending code = 4*row_index + col_index.
REQ-011 SHALL have port key_ack  input  1  consumer accepts the pending code.
REQ-012 SHALL have port key_held  output  1  a debounced key is currently down.
REQ-013 SHALL have port overrun  output  1  sticky: a code was dropped.

Function
REQ-014 SHALL pass column through a 2-flop synchronizer (reset to 4'b1111); all decisions use the synchronized value.
REQ-015 SHALL generate a tick when a free-running counter 0..SCAN_DIV-1 reaches SCAN_DIV-1; the counter wraps to 0.
REQ-016 SHALL drive row_index 0..3 as 4'b0111, 4'b1011, 4'b1101, 4'b1110; col_index 0..3 is the single low column bit, bit3 = 0 ... bit0 = 3.
REQ-017 SHALL implement FSM states SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-018 SCAN: on each tick, if the column has exactly one low bit, latch row_index/col_index, clear the debounce count, go DEBOUNCE with row frozen; otherwise advance row_index (3 wraps to 0).
REQ-019 SCAN: columns with two or more low bits (ghosting) SHALL be ignored and scanning SHALL continue.
REQ-020 DEBOUNCE: per tick, column equal to the latched value increments the count; any other value returns to SCAN and advances the row.
REQ-021 On reaching DEBOUNCE_CNT, the FSM SHALL issue a key event, go PRESSED and set key_held; key_valid SHALL rise the cycle after that tick.
REQ-022 PRESSED: a tick with column 4'b1111 SHALL go RELEASE with count cleared; any other value stays PRESSED.
REQ-023 RELEASE: DEBOUNCE_CNT consecutive 4'b1111 ticks SHALL clear key_held, advance the row and go SCAN; any low bit returns to PRESSED without a new event.
REQ-024 Row SHALL be frozen in DEBOUNCE, PRESSED and RELEASE.
REQ-025 On a key event with key_valid low, key_code SHALL load and key_valid SHALL set.
REQ-026 key_ack high while key_valid is high SHALL clear key_valid the next cycle; key_ack while key_valid is low SHALL be ignored.
REQ-027 If an event occurs while key_valid is high and key_ack is low, the new code SHALL be dropped, key_code kept and overrun set.
REQ-028 If an event and a valid key_ack coincide, the new code SHALL load and key_valid SHALL stay high without setting overrun.
REQ-029 overrun SHALL clear only on an accepted key_ack or on reset.

Reset
REQ-030 Reset SHALL force, asynchronously: state SCAN, row 4'b0111, tick and debounce counters 0, key_valid 0, key_code 0, key_held 0, overrun 0, synchronizer 4'b1111.
REQ-031 Reset asserted mid-press SHALL discard the press; after release, a key still held SHALL be re-detected and re-debounced from SCAN.

Configuration
REQ-032 With KEYPAD_REPEAT_EN defined: in PRESSED, REPEAT_DLY ticks after accept, then every REPEAT_RATE ticks, the FSM SHALL issue a key event with the same code, subject to REQ-025..028; the repeat counter clears on entering PRESSED from DEBOUNCE and holds while in RELEASE.
REQ-033 Without KEYPAD_REPEAT_EN: exactly one event per press; no repeat counter; REPEAT_DLY and REPEAT_RATE have no effect.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_DLY=5, REPEAT_RATE=2)
REQ-034 column=4'b1111 for 64 cycles -> row cycles 0111, 1011, 1101, 1110 with 4 cycles each; key_valid, key_held and overrun stay 0.
REQ-035 Hold column=4'b1101 while row=4'b1011 -> row frozen; key_valid=1 with key_code=6 the cycle after the 3rd matching tick; after key_ack, key_valid=0; after release plus 3 ticks, key_held=0 and scanning resumes at 4'b1101.
REQ-036 Press key 6 and return column to 4'b1111 after 1 matching tick -> no key_valid; scanning resumes.
REQ-037 Press key 0, release, press key 15, no key_ack -> key_code=0, overrun=1; key_ack -> key_valid=0, overrun=0.
REQ-038 Assert reset during DEBOUNCE -> next edge shows row=4'b0111 and all outputs 0; event and ack in the same cycle -> key_valid stays 1 with the new code.
REQ-039 With KEYPAD_REPEAT_EN, hold key 9 with immediate acks -> events at accept, accept+5 ticks, then every 2 ticks until release; without the macro -> exactly one event.

Source files
------------

// File: rtl/keypad_scan_sequencer.sv
// 4x4 keypad row scanner: debounced press/release, ghost rejection, one-deep code buffer.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan_sequencer #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 16,
  parameter int unsigned REPEAT_DLY   = 500,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] column,
  output logic [3:0] row,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overrun
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  localparam int unsigned TW = $clog2(SCAN_DIV);

  state_t        state, state_next;
  logic [3:0]    col_meta, col_sync, col_lat;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [1:0]    row_idx, row_idx_next, col_idx, col_enc;
  logic [7:0]    deb_cnt, deb_next;
  logic          one_low, latch, key_event, ack_ok;

  assign tick     = (tick_cnt == TW'(SCAN_DIV - 1));
  assign key_held = (state == PRESSED) || (state == RELEASE);
  assign ack_ok   = key_ack && key_valid;

  always_comb begin
    row = '1;
    row[2'd3 - row_idx] = 1'b0;
  end

  // Only a single low column is a usable press; anything else counts as no key.
  always_comb begin
    one_low = 1'b1;
    col_enc = 2'd0;
    case (col_sync)
      4'b0111: col_enc = 2'd0;
      4'b1011: col_enc = 2'd1;
      4'b1101: col_enc = 2'd2;
      4'b1110: col_enc = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RW =
    $clog2(((REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE) + 1);
  logic [RW-1:0] rep_cnt, rep_next;
  logic          rep_first, first_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
    end else begin
      rep_cnt   <= rep_next;
      rep_first <= first_next;
    end
  end
`else
  // Repeat timing parameters stay on the interface for drop-in compatibility.
  if (REPEAT_DLY == 0 && REPEAT_RATE == 0) begin : g_repeat_unused
  end
`endif

  always_comb begin
    state_next   = state;
    row_idx_next = row_idx;
    deb_next     = deb_cnt;
    latch        = 1'b0;
    key_event    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_next     = rep_cnt;
    first_next   = rep_first;
`endif
    if (tick) begin
      case (state)
        SCAN: begin
          if (one_low) begin
            latch      = 1'b1;
            deb_next   = '0;
            state_next = DEBOUNCE;
          end else begin
            row_idx_next = row_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (col_sync == col_lat) begin
            deb_next = deb_cnt + 8'd1;
            if (deb_next == 8'(DEBOUNCE_CNT)) begin
              key_event  = 1'b1;
              state_next = PRESSED;
`ifdef KEYPAD_REPEAT_EN
              rep_next   = '0;
              first_next = 1'b0;
`endif
            end
          end else begin
            state_next   = SCAN;
            row_idx_next = row_idx + 2'd1;
          end
        end
        PRESSED: begin
          if (col_sync == 4'b1111) begin
            state_next = RELEASE;
            deb_next   = '0;
          end else begin
`ifdef KEYPAD_REPEAT_EN
            rep_next = rep_cnt + RW'(1);
            if (rep_next == (rep_first ? RW'(REPEAT_RATE) : RW'(REPEAT_DLY))) begin
              key_event  = 1'b1;
              rep_next   = '0;
              first_next = 1'b1;
            end
`endif
          end
        end
        RELEASE: begin
          if (col_sync == 4'b1111) begin
            deb_next = deb_cnt + 8'd1;
            if (deb_next == 8'(DEBOUNCE_CNT)) begin
              state_next   = SCAN;
              row_idx_next = row_idx + 2'd1;
            end
          end else begin
            state_next = PRESSED;
          end
        end
        default: state_next = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_meta <= '1;
      col_sync <= '1;
      tick_cnt <= '0;
      state    <= SCAN;
      row_idx  <= '0;
      deb_cnt  <= '0;
      col_lat  <= '1;
      col_idx  <= '0;
    end else begin
      col_meta <= column;
      col_sync <= col_meta;
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      state    <= state_next;
      row_idx  <= row_idx_next;
      deb_cnt  <= deb_next;
      if (latch) begin
        col_lat <= col_sync;
        col_idx <= col_enc;
      end
    end
  end

  // An event coinciding with an accepted ack replaces the code instead of overrunning.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      overrun   <= 1'b0;
    end else begin
      if (key_event) begin
        if (!key_valid || key_ack) begin
          key_code  <= {row_idx, col_idx};
          key_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (ack_ok) begin
        key_valid <= 1'b0;
      end
      if (ack_ok) overrun <= 1'b0;
    end
  end

endmodule
